// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction field decoder with a 2-entry decoded-record FIFO
// Tracks the last retired destination to flag read-after-write hazards on the head entry.
module decode_stage #(
  parameter int RW   = 3,
  parameter int IW   = 16,
  parameter int DW   = 8,
  parameter int SEXT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [IW-1:0] in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_a,
  output logic [RW-1:0] out_b,
  output logic [RW-1:0] out_c,
  output logic [DW-1:0] out_imm,
  output logic          out_raw
);

  localparam int SW = RW + 2;
  localparam int LW = 2 * RW + 2;

  typedef struct packed {
    logic [RW-1:0] a;
    logic [RW-1:0] b;
    logic [RW-1:0] c;
    logic [DW-1:0] imm;
    logic          c_live;
  } rec_t;

  rec_t          dec;
  rec_t          e0;
  rec_t          e1;
  logic [1:0]    count;
  logic [1:0]    count_nxt;
  logic [RW-1:0] last_dest;
  logic          last_dest_vld;
  logic          push;
  logic          pop;
  logic [RW-1:0] f0;
  logic [RW-1:0] f1;
  logic [RW-1:0] f2;
  logic [SW-1:0] s_field;
  logic [LW-1:0] l_field;
  logic          unused_instr;

  function automatic logic [DW-1:0] ext_s(input logic [SW-1:0] f);
    logic [DW-1:0] r;
    r = DW'(f);
    if (SEXT != 0 && f[SW-1]) r = r | ({DW{1'b1}} << SW);
    return r;
  endfunction

  function automatic logic [DW-1:0] ext_l(input logic [LW-1:0] f);
    logic [DW-1:0] r;
    r = DW'(f);
    if (SEXT != 0 && f[LW-1]) r = r | ({DW{1'b1}} << LW);
    return r;
  endfunction

  assign f0           = in_instr[3*RW+1 -: RW];
  assign f1           = in_instr[2*RW+1 -: RW];
  assign f2           = in_instr[RW+1 -: RW];
  assign s_field      = in_instr[SW-1:0];
  assign l_field      = in_instr[LW-1:0];
  assign unused_instr = ^in_instr;

  always_comb begin
    dec        = '0;
    dec.a      = f0;
    dec.c_live = 1'b1;
    case (in_op)
      2'b00: begin
        dec.b = f1;
        dec.c = f2;
      end
      2'b01: begin
        dec.b   = f1;
        dec.c   = f2;
        dec.imm = ext_s(s_field);
      end
      2'b10: begin
        dec.b   = f0;
        dec.c   = f1;
        dec.imm = ext_s(s_field);
      end
      default: begin
        dec.b      = f0;
        dec.imm    = ext_l(l_field);
        dec.c_live = 1'b0;
      end
    endcase
  end

  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count_nxt = count + {1'b0, push} - {1'b0, pop};

  // Entry 0 is always the head, so outputs come straight from registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= 2'd0;
      in_ready      <= 1'b1;
      e0            <= '0;
      e1            <= '0;
      last_dest     <= '0;
      last_dest_vld <= 1'b0;
    end else if (flush) begin
      count         <= 2'd0;
      in_ready      <= 1'b1;
      last_dest_vld <= 1'b0;
    end else begin
      if (pop) begin
        last_dest     <= e0.a;
        last_dest_vld <= 1'b1;
      end
      case (count)
        2'd0: if (push) e0 <= dec;
        2'd1: begin
          if (push && pop) e0 <= dec;
          else if (push)   e1 <= dec;
        end
        default: if (pop) e0 <= e1;
      endcase
      count    <= count_nxt;
      in_ready <= (count_nxt < 2'd2);
    end
  end

  assign out_a   = e0.a;
  assign out_b   = e0.b;
  assign out_c   = e0.c;
  assign out_imm = e0.imm;
  assign out_raw = out_valid && last_dest_vld &&
                   (e0.b == last_dest || (e0.c_live && e0.c == last_dest));

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL provide parameter RW, default 3, register-field width in bits.
REQ-002 SHALL provide parameter IW, default 16, instruction width; legal only if IW >= 3*RW+2.
REQ-003 SHALL provide parameter DW, default 8, immediate output width; legal only if DW >= 2*RW+2.
REQ-004 SHALL provide parameter SEXT, default 0; 0 zero-extends immediates, 1 sign-extends them.
REQ-005 SHALL use one clock and one synchronous, active-high reset.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 flush  input  1  discards all buffered and output instructions.
REQ-009 in_valid  input  1  in_op/in_instr are valid.
REQ-010 in_ready  output  1  stage can accept an instruction this cycle.
REQ-011 in_op  input  2  format select.
REQ-012 in_instr  input  IW  instruction word.
REQ-013 out_valid  output  1  decoded fields are valid.
REQ-014 out_ready  input  1  downstream accepts the output.
REQ-015 out_a, out_b, out_c  output  RW each  decoded register addresses.
REQ-016 out_imm  output  DW  extended immediate.
REQ-017 out_raw  output  1  out_b or out_c matches the last retired out_a.

Function
REQ-018 Fields SHALL be F0=instr[3RW+1:2RW+2], F1=instr[2RW+1:RW+2], F2=instr[RW+1:2], S=instr[RW+1:0], L=instr[2RW+1:0].
REQ-019 op 00 SHALL decode a=F0, b=F1, c=F2, imm=0.
REQ-020 op 01 SHALL decode a=F0, b=F1, c=F2, imm=ext(S).
REQ-021 op 10 SHALL decode a=F0, b=F0, c=F1, imm=ext(S).
REQ-022 op 11 SHALL decode a=F0, b=F0, c=0, imm=ext(L).
REQ-023 ext() SHALL zero-fill to DW when SEXT=0 and replicate the field MSB when SEXT=1.
REQ-024 Input handshake SHALL occur when in_valid && in_ready; output handshake SHALL occur when out_valid && out_ready.
REQ-025 Decode SHALL happen at acceptance; an accepted instruction SHALL appear on the outputs no earlier than the next cycle (1-cycle latency when the stage is empty).
REQ-026 Storage SHALL be a 2-entry FIFO of decoded records; the output SHALL present the head entry; out_valid SHALL be 1 whenever count > 0.
REQ-027 in_ready SHALL be a registered signal equal to (count < 2) and SHALL NOT combinationally depend on out_ready.
REQ-028 When out_valid && !out_ready, all outputs SHALL stay stable.
REQ-029 A simultaneous accept and retire at count 1 or 2 SHALL leave count unchanged and preserve order.
REQ-030 At count 2, a retire SHALL raise in_ready the following cycle; no accept SHALL occur while in_ready is 0.
REQ-031 The stage SHALL keep last_dest (RW bits) and last_dest_vld (1 bit); each output handshake SHALL load last_dest=out_a and set last_dest_vld.
REQ-032 out_raw SHALL equal out_valid && last_dest_vld && (out_b==last_dest || (out_c==last_dest && op != 11)).
REQ-033 flush SHALL set count to 0, clear last_dest_vld, and ignore any same-cycle accept or retire.
REQ-034 Order SHALL be strictly FIFO: no loss, duplication or reordering.

Reset
REQ-035 rst SHALL dominate flush and SHALL set count=0, out_valid=0, in_ready=1, last_dest=0, last_dest_vld=0, out_a=out_b=out_c=0, out_imm=0, out_raw=0.
REQ-036 Reset mid-transfer SHALL drop all buffered instructions; the first post-reset accept SHALL behave as from empty.

Verification
REQ-037 Defaults: op=01, instr=0x07F5 -> next cycle out_a=7, out_b=7, out_c=5, out_imm=0x15, out_valid=1.
REQ-038 SEXT=1: op=11, instr=0x0380 -> out_a=3, out_b=3, out_c=0, out_imm=0x80; op=01, instr=0x0010 -> out_imm=0xF0.
REQ-039 Hold out_ready=0 and offer 3 instructions -> 2 accepted, in_ready=0, outputs stable; then out_ready=1 -> both retire in order and in_ready returns to 1.
REQ-040 Retire op=00 with out_a=2, then present out_b=2 -> out_raw=1; present op=11 with out_c=0 after retiring out_a=0 -> out_raw=1 only through out_b.
REQ-041 count=2, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_raw=0, nothing accepted.
REQ-042 Assert rst with count=2 and flush=1 -> all outputs at reset values next cycle; a random valid/ready stress sequence -> scoreboard finds no loss or reordering.
